register2_buff: RTL and testbench
=================================

REGISTER2_BUFF -- requirements
Module: register2_buff

Interface
REQ-001 Param WIDTH, default 32, data width of the register and of both bus ports.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 IN  inout  WIDTH  bidirectional bus A; sampled by Load, driven by Store.
REQ-005 IN2  inout  WIDTH  bidirectional bus B; sampled by Load2, driven by Store2.
REQ-006 Load  input  1  capture IN into the register at the next rising Clk.
REQ-007 Load2  input  1  capture IN2 into the register at the next rising Clk.
REQ-008 Store  input  1  drive register contents onto IN (tri-state enable).
REQ-009 Store2  input  1  drive register contents onto IN2 (tri-state enable).
REQ-010 Conflict  output  1  present only with REGISTER2_BUFF_CONFLICT_EN (see Configuration).

Function
REQ-011 The block SHALL hold one WIDTH-bit register Q.
REQ-012 On rising Clk with Reset high and Load=1, Q SHALL take IN; one-cycle latency.
REQ-013 On rising Clk with Reset high, Load=0 and Load2=1, Q SHALL take IN2.
REQ-014 Load SHALL have priority over Load2 when both are 1.
REQ-015 With Load=0 and Load2=0, Q SHALL hold its value indefinitely.
REQ-016 IN SHALL equal Q combinationally while Store=1; otherwise IN SHALL be released (all bits Z).
REQ-017 IN2 SHALL equal Q combinationally while Store2=1; otherwise IN2 SHALL be released (all bits Z).
REQ-018 Store and Store2 both 1 SHALL drive Q onto both buses at once.
REQ-019 A Load from the bus the block itself drives SHALL recapture Q unchanged.
REQ-020 The block SHALL not modify any Z or X bits on a sampled bus; a Load from a floating bus stores whatever value the bus carries.
REQ-021 Store/Store2 SHALL not affect Q; driven values change only after the Clk edge that updates Q.

Reset
REQ-022 Reset low SHALL force Q to 0 immediately, without waiting for Clk.
REQ-023 While Reset is low, Load/Load2 SHALL be ignored and IN and IN2 SHALL both be released to Z regardless of Store/Store2.
REQ-024 After Reset deasserts, the first rising Clk SHALL obey REQ-012..015 normally.
REQ-025 Conflict (if present) SHALL be 0 while Reset is low.

Configuration
REQ-026 Macro REGISTER2_BUFF_CONFLICT_EN: when defined, port Conflict SHALL exist and is registered.
REQ-027 Conflict SHALL be set on a rising Clk when (Load&Store2)|(Load2&Store)|(Load&Load2) is 1, and cleared at the next rising Clk where that term is 0.
REQ-028 Without the macro, the Conflict port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package register2_buff_pkg SHALL hold the WIDTH default constant and the all-Z release constant.
REQ-030 Each bus driver SHALL be an instance of sub-module tri_buffer (ports: data in, enable, bus out; WIDTH parameter); two instances.
REQ-031 Q and the load mux SHALL live in register2_buff; there SHALL be no other sub-modules.

Verification
REQ-032 Reset=0 with Q previously 5 -> Q=0 before the next Clk edge; IN and IN2 = Z.
REQ-033 Reset=1, IN=1, Load=1 for one edge, then Store=1 -> IN reads 1; IN2 stays Z.
REQ-034 IN=0, IN2=1, Load2=1 for one edge, Store2=1 -> IN2 reads 1; next IN=1, IN2=0, Load=1, Load2=1 -> Q=1 from IN (priority).
REQ-035 Q=1, Store=1 and Store2=1 together -> both IN and IN2 read 1; Q unchanged over 3 edges with no load.
REQ-036 Q=7, Store=1, Load=1 for one edge -> Q stays 7; with REGISTER2_BUFF_CONFLICT_EN, Store2=1 with Load=1 -> Conflict=1 after the edge, 0 one edge after removal.

Source files
------------

// File: rtl/register2_buff_pkg.sv
// rtl/register2_buff_pkg.sv - shared constants for register2_buff and its bus drivers
//
// REG_WIDTH_DEFAULT : default data width of the register and both buses
// RELEASE_Z_BIT     : the value a released bus bit takes, replicated to width by users
package register2_buff_pkg;

  localparam int   REG_WIDTH_DEFAULT = 32;
  localparam logic RELEASE_Z_BIT     = 1'bz;

endpackage

// File: rtl/tri_buffer.sv
// rtl/tri_buffer.sv - tri-state bus driver, drives data onto bus when enabled
//
// Ports:
//   data   : value to place on the bus
//   enable : 1 = drive data, 0 = release bus (all bits Z)
//   bus    : tri-state bus output
module tri_buffer
  import register2_buff_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  output wire  [WIDTH-1:0] bus
);

  assign bus = enable ? data : {WIDTH{RELEASE_Z_BIT}};

endmodule

// File: rtl/register2_buff.sv
// rtl/register2_buff.sv - one register shared by two bidirectional buses
//
// Optional feature macro: REGISTER2_BUFF_CONFLICT_EN (adds registered Conflict output)
//
// Ports:
//   Clk      : clock, rising edge
//   Reset    : asynchronous active-low reset
//   IN, IN2  : bidirectional buses A and B
//   Load     : capture IN into Q at next Clk (priority over Load2)
//   Load2    : capture IN2 into Q at next Clk
//   Store    : drive Q onto IN
//   Store2   : drive Q onto IN2
//   Conflict : (macro only) registered flag for simultaneous load/drive collisions
module register2_buff
  import register2_buff_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  inout  wire  [WIDTH-1:0] IN,
  inout  wire  [WIDTH-1:0] IN2,
  input  logic             Load,
  input  logic             Load2,
  input  logic             Store,
  input  logic             Store2
`ifdef REGISTER2_BUFF_CONFLICT_EN
  ,
  output logic             Conflict
`endif
);

  logic [WIDTH-1:0] q;

  // Bus values are captured as seen, including any Z/X bits on a floating bus.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q <= '0;
    end else if (Load) begin
      q <= IN;
    end else if (Load2) begin
      q <= IN2;
    end
  end

  // Drivers are gated by Reset so both buses float while reset is held.
  tri_buffer #(.WIDTH(WIDTH)) u_drv_a (
    .data   (q),
    .enable (Store & Reset),
    .bus    (IN)
  );

  tri_buffer #(.WIDTH(WIDTH)) u_drv_b (
    .data   (q),
    .enable (Store2 & Reset),
    .bus    (IN2)
  );

`ifdef REGISTER2_BUFF_CONFLICT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Conflict <= 1'b0;
    end else begin
      Conflict <= (Load & Store2) | (Load2 & Store) | (Load & Load2);
    end
  end
`endif

endmodule

// File: tb/tb_register2_buff.sv
// tb/tb_register2_buff.sv - self-checking bench for register2_buff
module tb_register2_buff;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         ld, ld2, st, st2;
  logic         a_en, b_en;
  logic [W-1:0] a_val, b_val;
  wire  [W-1:0] bus_a, bus_b;
  logic [W-1:0] q_m;
  int           total;
  int           bad;

  assign bus_a = a_en ? a_val : 'z;
  assign bus_b = b_en ? b_val : 'z;

`ifdef REGISTER2_BUFF_CONFLICT_EN
  logic conflict;
  logic conf_m;
`endif

  register2_buff #(.WIDTH(W)) dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .IN       (bus_a),
    .IN2      (bus_b),
    .Load     (ld),
    .Load2    (ld2),
    .Store    (st),
    .Store2   (st2)
`ifdef REGISTER2_BUFF_CONFLICT_EN
    ,
    .Conflict (conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: value each bus carries is the TB drive unless the block stores onto it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m <= '0;
    end else if (ld) begin
      q_m <= st ? q_m : a_val;
    end else if (ld2) begin
      q_m <= st2 ? q_m : b_val;
    end
  end

`ifdef REGISTER2_BUFF_CONFLICT_EN
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) conf_m <= 1'b0;
    else        conf_m <= (ld & st2) | (ld2 & st) | (ld & ld2);
  end
`endif

  // Apply one cycle of controls at the falling edge; the bench drives a bus only
  // when the block is not storing onto it, so there is never contention.
  task automatic drive_cycle(input logic l, input logic l2, input logic s, input logic s2,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    ld = l; ld2 = l2; st = s; st2 = s2;
    a_val = a; b_val = b;
    a_en = !s; b_en = !s2;
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    total++;
    if (bus_a !== 32'd5) begin
      bad++; $display("FAIL reset_preload: got %h want %h", bus_a, 32'd5);
    end
    // Short reset pulse between edges must clear Q with no clock
    rst_n = 1'b0; #1; rst_n = 1'b1; #1;
    total++;
    if (bus_a !== 32'd0) begin
      bad++; $display("FAIL reset_async_clear: got %h want %h", bus_a, 32'd0);
    end
    // Hold reset over an edge with every control asserted
    @(negedge clk);
    rst_n = 1'b0; ld = 1; ld2 = 1; st = 1; st2 = 1;
    a_en = 1; b_en = 1; a_val = $urandom; b_val = $urandom;
    #1;
    total++;
    if (bus_a !== a_val) begin
      bad++; $display("FAIL reset_release_a: got %h want %h", bus_a, a_val);
    end
    total++;
    if (bus_b !== b_val) begin
      bad++; $display("FAIL reset_release_b: got %h want %h", bus_b, b_val);
    end
    @(posedge clk); #1;
    total++;
    if (bus_a !== a_val || bus_b !== b_val) begin
      bad++; $display("FAIL reset_release_edge: got %h/%h want %h/%h", bus_a, bus_b, a_val, b_val);
    end
`ifdef REGISTER2_BUFF_CONFLICT_EN
    total++;
    if (conflict !== 1'b0) begin
      bad++; $display("FAIL reset_conflict: got %b want 0", conflict);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1; ld = 0; ld2 = 0; a_en = 0; b_en = 0;
    #1;
    total++;
    if (bus_a !== 32'd0 || bus_b !== 32'd0) begin
      bad++; $display("FAIL reset_loads_ignored: got %h/%h want 0/0", bus_a, bus_b);
    end
  endtask

  task automatic test_load_store();
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] v, w;
      logic use_b;
      v = (i == 0) ? 32'd1 : $urandom;
      w = $urandom;
      use_b = i[0];
      if (use_b) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, w, v);
      else       drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, v, w);
      // Read back on each bus in turn while the bench drives the other
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, w);
      total++;
      if (bus_a !== q_m || q_m !== v || bus_b !== w) begin
        bad++; $display("FAIL load_store_a[%0d]: got %h/%h want %h/%h", i, bus_a, bus_b, v, w);
      end
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, w, 32'd0);
      total++;
      if (bus_b !== v || bus_a !== w) begin
        bad++; $display("FAIL load_store_b[%0d]: got %h/%h want %h/%h", i, bus_b, bus_a, v, w);
      end
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      a = (i == 0) ? 32'd1 : $urandom;
      b = (i == 0) ? 32'd0 : ~a;
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, a, b);
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0);
      total++;
      if (bus_a !== a || bus_b !== a) begin
        bad++; $display("FAIL priority[%0d]: got %h/%h want %h", i, bus_a, bus_b, a);
      end
    end
  endtask

  task automatic test_dual_store_hold();
    logic [W-1:0] v;
    v = $urandom;
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, v);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0);
      total++;
      if (bus_a !== v || bus_b !== v) begin
        bad++; $display("FAIL dual_store_hold[%0d]: got %h/%h want %h", i, bus_a, bus_b, v);
      end
    end
  endtask

  task automatic test_self_load();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1234);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h5678, 32'd0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0);
    total++;
    if (bus_a !== 32'd7 || bus_b !== 32'd7) begin
      bad++; $display("FAIL self_load: got %h/%h want %h", bus_a, bus_b, 32'd7);
    end
  endtask

`ifdef REGISTER2_BUFF_CONFLICT_EN
  task automatic test_conflict();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'd9, 32'd0);
    @(posedge clk); #1;
    total++;
    if (conflict !== 1'b1) begin
      bad++; $display("FAIL conflict_set: got %b want 1", conflict);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    total++;
    if (conflict !== 1'b0) begin
      bad++; $display("FAIL conflict_clear: got %b want 0", conflict);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic l, l2, s, s2;
      l = $urandom_range(0, 1); l2 = $urandom_range(0, 1);
      s = $urandom_range(0, 1); s2 = $urandom_range(0, 1);
      drive_cycle(l, l2, s, s2, $urandom, $urandom);
      total++;
      if (bus_a !== (s ? q_m : a_val)) begin
        bad++; $display("FAIL random_bus_a[%0d]: got %h want %h", i, bus_a, s ? q_m : a_val);
      end
      total++;
      if (bus_b !== (s2 ? q_m : b_val)) begin
        bad++; $display("FAIL random_bus_b[%0d]: got %h want %h", i, bus_b, s2 ? q_m : b_val);
      end
`ifdef REGISTER2_BUFF_CONFLICT_EN
      total++;
      if (conflict !== conf_m) begin
        bad++; $display("FAIL random_conflict[%0d]: got %b want %b", i, conflict, conf_m);
      end
`endif
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    ld = 0; ld2 = 0; st = 0; st2 = 0;
    a_en = 0; b_en = 0; a_val = '0; b_val = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_load_store();
    test_priority();
    test_dual_store_hold();
    test_self_load();
`ifdef REGISTER2_BUFF_CONFLICT_EN
    test_conflict();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
